// File: rtl/imem_arbiter.sv
// Two-requester arbiter (fetch, load) for a single-ported instruction memory with a one-cycle read latency.
// Optional misaligned-address trapping is enabled by defining IMEM_ARB_MISALIGN_CHK_EN.
module imem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    input  logic                     if_flush,
    input  logic                     ld_req,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    output logic                     if_gnt,
    output logic                     ld_gnt,
    output logic                     if_rvalid,
    output logic                     ld_rvalid,
    output logic [31:0]              if_rdata,
    output logic [31:0]              ld_rdata,
    output logic                     rsp_err,
    output logic                     mem_en,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [31:0]              mem_rdata
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_LD   = 2'd2;

    logic [3:0]               starve_cnt;
    logic [1:0]               rsp_owner;
    logic                     rst_q;
    logic                     rsp_mis;
    logic                     blk;
    logic                     fetch_wins;
    logic                     any_gnt;
    logic                     misaligned;
    logic [ADDRESS_WIDTH-1:0] gnt_addr;

    // Grants are held off during reset and for the first cycle after it.
    assign blk        = rst | rst_q;
    assign fetch_wins = !ld_req || (starve_cnt >= 4'(STARVE_LIMIT));
    assign if_gnt     = !blk && if_req && fetch_wins;
    assign ld_gnt     = !blk && ld_req && !if_gnt;
    assign any_gnt    = if_gnt || ld_gnt;
    assign gnt_addr   = if_gnt ? if_addr : (ld_gnt ? ld_addr : '0);
    assign mem_addr   = gnt_addr;

`ifdef IMEM_ARB_MISALIGN_CHK_EN
    assign misaligned = any_gnt && (gnt_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign mem_en = any_gnt && !misaligned;

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            starve_cnt <= 4'd0;
            rsp_owner  <= OWN_NONE;
            rsp_mis    <= 1'b0;
        end else begin
            if (if_req && !if_gnt)
                starve_cnt <= (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
            else
                starve_cnt <= 4'd0;
            rsp_owner <= if_gnt ? OWN_IF : (ld_gnt ? OWN_LD : OWN_NONE);
            rsp_mis   <= misaligned;
        end
    end

    assign if_rvalid = !rst && (rsp_owner == OWN_IF) && !if_flush;
    assign ld_rvalid = !rst && (rsp_owner == OWN_LD);
    assign if_rdata  = (if_rvalid && !rsp_mis) ? mem_rdata : 32'd0;
    assign ld_rdata  = (ld_rvalid && !rsp_mis) ? mem_rdata : 32'd0;

`ifdef IMEM_ARB_MISALIGN_CHK_EN
    assign rsp_err = (if_rvalid || ld_rvalid) && rsp_mis;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, byte-address width of both requesters and the memory port.
REQ-002 SHALL have parameter STARVE_LIMIT, default 3, consecutive denied fetch cycles after which fetch wins arbitration; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port if_req  input  1  fetch requester wants a word this cycle.
REQ-006 SHALL have port if_addr  input  ADDRESS_WIDTH  fetch byte address.
REQ-007 SHALL have port if_flush  input  1  cancel any fetch response due next cycle (branch redirect).
REQ-008 SHALL have port ld_req  input  1  load requester wants a word this cycle.
REQ-009 SHALL have port ld_addr  input  ADDRESS_WIDTH  load byte address.
REQ-010 SHALL have ports if_gnt and ld_gnt  output  1 each  request accepted this cycle (combinational).
REQ-011 SHALL have ports if_rvalid and ld_rvalid  output  1 each  response word valid this cycle.
REQ-012 SHALL have ports if_rdata and ld_rdata  output  32 each  response word, little-endian byte order.
REQ-013 SHALL have port rsp_err  output  1  response carries misaligned-address error (see Configuration).
REQ-014 SHALL have ports mem_en  output  1 and mem_addr  output  ADDRESS_WIDTH  single-ported instruction memory read request.
REQ-015 SHALL have port mem_rdata  input  32  memory word, valid exactly one cycle after mem_en.

Function
REQ-016 SHALL grant at most one requester per cycle; mem_en = if_gnt | ld_gnt; mem_addr = address of granted requester, else 0.
REQ-017 SHALL give load priority when both request, unless starve_cnt >= STARVE_LIMIT, in which case fetch is granted.
REQ-018 SHALL keep a 4-bit starve_cnt: +1 (saturating at 15) each cycle if_req is high and if_gnt low; cleared on if_gnt or when if_req is low.
REQ-019 SHALL track response ownership in a 2-state-plus-idle register rsp_owner {NONE, IF, LD}, loaded each cycle from the grant.
REQ-020 SHALL assert if_rvalid one cycle after if_gnt with if_rdata = mem_rdata, unless if_flush is high in that response cycle, in which case if_rvalid stays 0.
REQ-021 SHALL assert ld_rvalid one cycle after ld_gnt with ld_rdata = mem_rdata; if_flush SHALL NOT affect load responses.
REQ-022 SHALL drive if_rdata/ld_rdata to 0 whenever the corresponding rvalid is 0.
REQ-023 SHALL sustain one grant per cycle (back-to-back grants, full throughput); a new grant in the response cycle is legal.
REQ-024 SHALL ignore if_addr/ld_addr when the matching req is low.

Reset
REQ-025 SHALL, while rst is high at a clock edge, clear starve_cnt to 0 and rsp_owner to NONE.
REQ-026 SHALL force all gnt, rvalid, mem_en and rsp_err outputs to 0 in any cycle rst is high; outputs SHALL be 0 in the first cycle after reset deasserts.
REQ-027 SHALL discard a response in flight when reset is asserted in its response cycle (no rvalid after reset).

Configuration
REQ-028 SHALL, with macro IMEM_ARB_MISALIGN_CHK_EN defined, not drive mem_en for a granted request with addr[1:0] != 0, and instead assert the owner's rvalid next cycle with rsp_err=1 and rdata=0 (starve/priority unaffected).
REQ-029 SHALL, without IMEM_ARB_MISALIGN_CHK_EN, pass all addresses to memory unmodified and tie rsp_err to 0.

Verification
REQ-030 SHALL cover: if_req=1, if_addr=0x10, ld_req=0 -> if_gnt=1, mem_addr=0x10; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-031 SHALL cover: if_req and ld_req high continuously, STARVE_LIMIT=3 -> grants LD,LD,LD,IF,LD,LD,LD,IF...
REQ-032 SHALL cover: if_gnt at cycle N, if_flush=1 at N+1 -> if_rvalid=0 at N+1; simultaneous ld_gnt at N+1 yields ld_rvalid=1 at N+2.
REQ-033 SHALL cover: ld_gnt at cycle N, rst=1 at N+1 -> ld_rvalid=0 at N+1 and N+2, starve_cnt=0.
REQ-034 SHALL cover (macro defined): ld_addr=0x0000_0006 granted -> mem_en=0; next cycle ld_rvalid=1, rsp_err=1, ld_rdata=0; (macro undefined) mem_addr=0x6, rsp_err=0.
